// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: core-side controller for one bank of tri-state GPIO pads.
// Registers the pad control lines, resynchronises the pad return through two
// flops, optionally debounces each pin and raises sticky rise/fall pending bits.
module gpio_pad_ctrl #(
  parameter int NUM_PINS     = 8,
  parameter int DB_CNT_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_PINS-1:0]     out_i,
  input  logic [NUM_PINS-1:0]     oen_i,
  input  logic [NUM_PINS-1:0]     ren_i,
  input  logic [NUM_PINS-1:0]     db_en_i,
  input  logic [DB_CNT_WIDTH-1:0] db_thresh_i,
  input  logic [NUM_PINS-1:0]     irq_rise_en_i,
  input  logic [NUM_PINS-1:0]     irq_fall_en_i,
  input  logic [NUM_PINS-1:0]     irq_clr_i,
  output logic [NUM_PINS-1:0]     pad_i_o,
  output logic [NUM_PINS-1:0]     pad_oen_o,
  output logic [NUM_PINS-1:0]     pad_ren_o,
  input  logic [NUM_PINS-1:0]     pad_c_i,
  output logic [NUM_PINS-1:0]     in_o,
  output logic [NUM_PINS-1:0]     irq_pend_o,
  output logic                    irq_o
);

  logic [NUM_PINS-1:0]     pad_i_q, pad_oen_q, pad_ren_q;
  logic [NUM_PINS-1:0]     pend_d_all;
  logic                    irq_q;
  logic [1:0]              warm_q;
  logic                    armed;
  logic [DB_CNT_WIDTH-1:0] t_m1;

  // A threshold of zero behaves like one: accept on the first differing cycle.
  assign t_m1 = (db_thresh_i == '0) ? '0 : db_thresh_i - DB_CNT_WIDTH'(1);

  // Edges are ignored for the first three edges after reset, while the
  // synchroniser fills with the real pad levels and the unfiltered value
  // settles; otherwise a pin held high through reset would look like a rise.
  assign armed = (warm_q == 2'd3);

  // Pad control registers, warm-up counter and the registered interrupt line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_i_q   <= '0;
      pad_oen_q <= '0;
      pad_ren_q <= '1;
      warm_q    <= 2'd0;
      irq_q     <= 1'b0;
    end else begin
      pad_i_q   <= out_i;
      pad_oen_q <= oen_i;
      pad_ren_q <= ren_i;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      irq_q     <= |pend_d_all;
    end
  end

  assign pad_i_o   = pad_i_q;
  assign pad_oen_o = pad_oen_q;
  assign pad_ren_o = pad_ren_q;
  assign irq_o     = irq_q;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    logic                    s1_q, s2_q;
    logic                    stable_q, stable_d;
    logic                    pend_q, pend_d;
    logic                    rise, fall;
    logic [DB_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Debounce decision and pending-bit update for this pin.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (!db_en_i[gi]) begin
        stable_d = s2_q;
      end else if (s2_q != stable_q) begin
        // >= rather than == so a threshold lowered mid-count takes effect at once.
        if (cnt_q >= t_m1) stable_d = s2_q;
        else               cnt_d    = cnt_q + DB_CNT_WIDTH'(1);
      end
      rise   = armed & ~stable_q &  stable_d;
      fall   = armed &  stable_q & ~stable_d;
      // Set is ORed in after the clear so a same-edge set wins.
      pend_d = (pend_q & ~irq_clr_i[gi])
             | (rise & irq_rise_en_i[gi])
             | (fall & irq_fall_en_i[gi]);
    end

    // Synchroniser, filtered value, debounce counter and pending flop.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
        pend_q   <= 1'b0;
      end else begin
        s1_q     <= pad_c_i[gi];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
      end
    end

    assign in_o[gi]       = stable_q;
    assign irq_pend_o[gi] = pend_q;
    assign pend_d_all[gi] = pend_d;
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: scoreboard bench for gpio_pad_ctrl. The stimulus side runs a
// behavioural model at every edge and queues the expected outputs; a monitor
// pops one entry after each edge and compares it with the DUT.
module tb_gpio_pad_ctrl;
  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] out_v, oen_v, ren_v, db_en, rise_en, fall_en, clr, pad_c;
  logic [W-1:0] thresh;
  logic [N-1:0] pad_i, pad_oen, pad_ren, in_v, pend;
  logic         irq;

  gpio_pad_ctrl #(.NUM_PINS(N), .DB_CNT_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .out_i(out_v), .oen_i(oen_v), .ren_i(ren_v),
    .db_en_i(db_en), .db_thresh_i(thresh), .irq_rise_en_i(rise_en),
    .irq_fall_en_i(fall_en), .irq_clr_i(clr), .pad_i_o(pad_i),
    .pad_oen_o(pad_oen), .pad_ren_o(pad_ren), .pad_c_i(pad_c), .in_o(in_v),
    .irq_pend_o(pend), .irq_o(irq)
  );

  typedef struct packed {
    logic [N-1:0] pi, po, pr, in, pend;
    logic         irq;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pad levels seen two edges late, a per-pin tally of
  // consecutive disagreeing cycles, and edges inferred from the filtered value.
  logic [N-1:0] m_pi, m_po, m_pr, m_s1, m_s2, m_st, m_pend;
  logic         m_irq;
  int           m_cnt [N];
  int           m_warm;

  function automatic void cmp(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pi = '0; m_po = '0; m_pr = '1; m_s1 = '0; m_s2 = '0; m_st = '0;
    m_pend = '0; m_irq = 1'b0; m_warm = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_step();
    int           t;
    logic [N-1:0] old_st, set_m;
    if (rst) begin
      model_reset();
      return;
    end
    t      = (thresh == 0) ? 1 : int'(thresh);
    old_st = m_st;
    for (int i = 0; i < N; i++) begin
      if (!db_en[i]) begin
        m_st[i] = m_s2[i];
        m_cnt[i] = 0;
      end else if (m_s2[i] == m_st[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] + 1 >= t) begin
        m_st[i] = m_s2[i];
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_s2 = m_s1;
    m_s1 = pad_c;
    set_m = (m_warm < 3) ? '0
          : ((~old_st & m_st & rise_en) | (old_st & ~m_st & fall_en));
    m_pend = (m_pend & ~clr) | set_m;
    m_irq  = |m_pend;
    m_pi = out_v; m_po = oen_v; m_pr = ren_v;
    if (m_warm < 3) m_warm++;
  endfunction

  // One clock: called at a negedge with inputs already set.
  task automatic tick();
    exp_t e;
    model_step();
    e.pi = m_pi; e.po = m_po; e.pr = m_pr; e.in = m_st; e.pend = m_pend; e.irq = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: one expected entry per edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pad_i_o",    pad_i,   e.pi);
        cmp("pad_oen_o",  pad_oen, e.po);
        cmp("pad_ren_o",  pad_ren, e.pr);
        cmp("in_o",       in_v,    e.in);
        cmp("irq_pend_o", pend,    e.pend);
        cmp("irq_o",      {{(N-1){1'b0}}, irq}, {{(N-1){1'b0}}, e.irq});
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1; out_v = '0; oen_v = '0; ren_v = 8'h0F; db_en = '0;
    rise_en = '0; fall_en = '0; clr = '0; pad_c = '1; thresh = '0;
    @(negedge clk);

    // 1: reset with pads high, then no interrupt from the resync.
    ticks(2);
    cmp("t1_oen", pad_oen, 8'h00);
    cmp("t1_ren", pad_ren, 8'hFF);
    cmp("t1_pend", pend, 8'h00);
    cmp("t1_irq", {{(N-1){1'b0}}, irq}, 8'h00);
    rst = 1'b0; rise_en = '1;
    ticks(6);
    cmp("t1_in_resync", in_v, 8'hFF);
    cmp("t1_no_resync_irq", pend, 8'h00);
    rise_en = '0;

    // 2: drive and loopback.
    out_v = 8'hA5; oen_v = 8'hFF;
    tick();
    cmp("t2_pad_i", pad_i, 8'hA5);
    cmp("t2_pad_oen", pad_oen, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      pad_c = m_pi;
      tick();
    end
    cmp("t2_loopback", in_v, 8'hA5);

    // 3: debounce with T=4 on pin 0.
    out_v = '0; oen_v = '0; pad_c = '0; db_en = 8'h01; thresh = 8'd4;
    ticks(6);
    pad_c[0] = 1'b1; ticks(3);
    pad_c[0] = 1'b0; ticks(6);
    cmp("t3_glitch_rejected", {{(N-1){1'b0}}, in_v[0]}, 8'h00);
    pad_c[0] = 1'b1; ticks(4);
    pad_c[0] = 1'b0; ticks(1);
    cmp("t3_not_yet", {{(N-1){1'b0}}, in_v[0]}, 8'h00);
    ticks(1);
    cmp("t3_accepted", {{(N-1){1'b0}}, in_v[0]}, 8'h01);
    ticks(8);
    db_en = '0;

    // 4: rise-only interrupt on pin 2, then clear.
    rise_en = 8'h04; fall_en = 8'h00;
    pad_c[2] = 1'b1; ticks(3);
    pad_c[2] = 1'b0; ticks(4);
    cmp("t4_pend", pend, 8'h04);
    cmp("t4_irq", {{(N-1){1'b0}}, irq}, 8'h01);
    clr = 8'h04; tick(); clr = '0;
    cmp("t4_cleared", pend, 8'h00);
    cmp("t4_irq_low", {{(N-1){1'b0}}, irq}, 8'h00);

    // 5: clear and set on the same edge, set wins.
    rise_en = 8'h08;
    pad_c[3] = 1'b1; ticks(2);
    clr = 8'h08; tick(); clr = '0;
    cmp("t5_set_wins", pend, 8'h08);
    clr = '1; tick(); clr = '0;
    pad_c = '0; rise_en = '0; ticks(4);

    // 6: reset in the middle of a T=10 count on pin 1.
    thresh = 8'd10; db_en = 8'h02;
    ticks(3);
    pad_c[1] = 1'b1; ticks(6);
    cmp("t6_mid_count", {{(N-1){1'b0}}, in_v[1]}, 8'h00);
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("t6_rst_in", in_v, 8'h00);
    cmp("t6_rst_pend", pend, 8'h00);
    ticks(11);
    cmp("t6_still_counting", {{(N-1){1'b0}}, in_v[1]}, 8'h00);
    tick();
    cmp("t6_accepted", {{(N-1){1'b0}}, in_v[1]}, 8'h01);
    db_en = '0; thresh = '0;

    // Randomised traffic with slowly toggling pads so the filter can settle.
    for (int c = 0; c < 1500; c++) begin
      out_v = N'($urandom); oen_v = N'($urandom); ren_v = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pad_c[i] = ~pad_c[i];
      if ($urandom_range(0, 40) == 0) db_en   = N'($urandom);
      if ($urandom_range(0, 60) == 0) thresh  = W'($urandom_range(0, 5));
      if ($urandom_range(0, 30) == 0) rise_en = N'($urandom);
      if ($urandom_range(0, 30) == 0) fall_en = N'($urandom);
      clr = N'($urandom) & N'($urandom) & N'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; clr = '0;
    ticks(2);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
